// File: rtl/ibuf_ctl_pkg.sv
// Shared IFU definitions for the instruction byte buffer: sizes, byte-lane type
// and the decode-window valid helper.
package ibuf_ctl_pkg;

    localparam int unsigned IBUF_DEPTH      = 16;
    localparam int unsigned IBUF_FILL_BYTES = 4;
    localparam int unsigned IBUF_WIN        = 7;
    localparam int unsigned IBUF_CNT_W      = 5;

    typedef logic [7:0]            byte_t;
    typedef logic [IBUF_CNT_W-1:0] cnt_t;

    // Thermometer valid vector: bit n set when more than n bytes are buffered.
    function automatic logic [IBUF_WIN-1:0] therm_valid(input cnt_t cnt);
        logic [IBUF_WIN-1:0] v;
        v = {IBUF_WIN{1'b0}};
        for (int n = 0; n < int'(IBUF_WIN); n++) begin
            v[n] = (cnt > cnt_t'(n));
        end
        return v;
    endfunction

endpackage

// File: rtl/ibuf_ctl_if.sv
// Fill / consume / decode-window bundle between the IFU fill path, the folding
// decoders and the instruction byte buffer.
interface ibuf_ctl_if;
    import ibuf_ctl_pkg::*;

    logic [8*IBUF_FILL_BYTES-1:0] fill_data;
    logic [2:0]                   fill_cnt;
    logic                         fill_val;
    logic                         fill_rdy;
    logic [2:0]                   consume_len;
    logic                         flush;
    byte_t                        ibuff_0;
    byte_t                        ibuff_1;
    byte_t                        ibuff_2;
    byte_t                        ibuff_3;
    byte_t                        ibuff_4;
    byte_t                        ibuff_5;
    byte_t                        ibuff_6;
    logic [IBUF_WIN-1:0]          fetch_valid;
    cnt_t                         ibuf_cnt;
    logic                         ibuf_undf;

    modport master (
        output fill_data, fill_cnt, fill_val, consume_len, flush,
        input  fill_rdy, ibuff_0, ibuff_1, ibuff_2, ibuff_3, ibuff_4, ibuff_5,
               ibuff_6, fetch_valid, ibuf_cnt, ibuf_undf
    );

    modport slave (
        input  fill_data, fill_cnt, fill_val, consume_len, flush,
        output fill_rdy, ibuff_0, ibuff_1, ibuff_2, ibuff_3, ibuff_4, ibuff_5,
               ibuff_6, fetch_valid, ibuf_cnt, ibuf_undf
    );

endinterface

// File: rtl/ibuf_byte_shift.sv
// Combinational compaction of the byte array (left shift by the retired length)
// followed by a merge of the new fill bytes at the post-shift tail.
module ibuf_byte_shift import ibuf_ctl_pkg::*; #(
    parameter int unsigned DEPTH      = IBUF_DEPTH,
    parameter int unsigned FILL_BYTES = IBUF_FILL_BYTES
) (
    input  byte_t                   arr_i [DEPTH],
    input  logic [2:0]              shift_i,
    input  logic [8*FILL_BYTES-1:0] fill_data_i,
    input  logic [2:0]              fill_cnt_i,
    input  cnt_t                    wr_ofs_i,
    output byte_t                   arr_o [DEPTH]
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = AW + 1;
    localparam int unsigned FW = $clog2(FILL_BYTES);

    byte_t shifted_s [DEPTH];
    byte_t fill_b_s  [FILL_BYTES];

    // Vacated tail positions are zero-filled.
    always_comb begin
        logic [SW-1:0] src;
        src = {SW{1'b0}};
        for (int i = 0; i < int'(DEPTH); i++) begin
            src = SW'(i) + SW'(shift_i);
            if (src < SW'(DEPTH)) begin
                shifted_s[i] = arr_i[src[AW-1:0]];
            end else begin
                shifted_s[i] = 8'h00;
            end
        end
    end

    // Fill lane 0 is the MSB byte of the fill word, i.e. earliest in program order.
    always_comb begin
        for (int k = 0; k < int'(FILL_BYTES); k++) begin
            fill_b_s[k] = fill_data_i[8*(int'(FILL_BYTES)-1-k) +: 8];
        end
    end

    // Merge accepted fill bytes at positions wr_ofs_i .. wr_ofs_i+fill_cnt_i-1.
    always_comb begin
        cnt_t rel;
        rel = 5'd0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rel = cnt_t'(i) - wr_ofs_i;
            if ((cnt_t'(i) >= wr_ofs_i) && (rel < cnt_t'(fill_cnt_i))) begin
                arr_o[i] = fill_b_s[rel[FW-1:0]];
            end else begin
                arr_o[i] = shifted_s[i];
            end
        end
    end

endmodule

// File: rtl/ibuf_ctl.sv
// Instruction byte buffer: oldest-first byte array feeding the 7-byte decode
// window, with retire, fill, underflow tracking and flush.
module ibuf_ctl import ibuf_ctl_pkg::*; #(
    parameter int unsigned DEPTH      = IBUF_DEPTH,
    parameter int unsigned FILL_BYTES = IBUF_FILL_BYTES
) (
    input  logic       clk,
    input  logic       reset_l,
    ibuf_ctl_if.slave  bus
);

    byte_t               arr_q     [DEPTH];
    byte_t               arr_d     [DEPTH];
    byte_t               shift_o_s [DEPTH];
    cnt_t                count_q;
    cnt_t                count_d;
    logic                undf_q;
    logic                undf_d;
    logic [IBUF_WIN-1:0] fv_q;
    logic [IBUF_WIN-1:0] fv_d;
    logic [2:0]          cons_s;
    logic [2:0]          fcnt_s;
    logic                over_s;
    logic                fill_acc_s;
    logic                fill_rdy_s;
    cnt_t                wr_ofs_s;

    // Conservative: ignores bytes retired in the same cycle.
    assign fill_rdy_s = (cnt_t'(DEPTH) - count_q) >= cnt_t'(FILL_BYTES);

    // Clamp the retire length to occupancy before any subtraction, and gate the fill.
    always_comb begin
        over_s = cnt_t'(bus.consume_len) > count_q;
        if (over_s) begin
            cons_s = count_q[2:0];
        end else begin
            cons_s = bus.consume_len;
        end
        fill_acc_s = bus.fill_val & fill_rdy_s & ~bus.flush;
        if (!fill_acc_s) begin
            fcnt_s = 3'd0;
        end else if (bus.fill_cnt > 3'(FILL_BYTES)) begin
            fcnt_s = 3'(FILL_BYTES);
        end else begin
            fcnt_s = bus.fill_cnt;
        end
        wr_ofs_s = count_q - cnt_t'(cons_s);
    end

    ibuf_byte_shift #(
        .DEPTH      (DEPTH),
        .FILL_BYTES (FILL_BYTES)
    ) u_shift (
        .arr_i       (arr_q),
        .shift_i     (cons_s),
        .fill_data_i (bus.fill_data),
        .fill_cnt_i  (fcnt_s),
        .wr_ofs_i    (wr_ofs_s),
        .arr_o       (shift_o_s)
    );

    // Next state; flush wins over retire and fill, and leaves storage stale.
    always_comb begin
        if (bus.flush) begin
            count_d = 5'd0;
            undf_d  = 1'b0;
            arr_d   = arr_q;
        end else begin
            count_d = wr_ofs_s + cnt_t'(fcnt_s);
            undf_d  = undf_q | over_s;
            arr_d   = shift_o_s;
        end
        fv_d = therm_valid(count_d);
    end

    // State and registered window/valid outputs.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                arr_q[i] <= 8'h00;
            end
            count_q <= 5'd0;
            undf_q  <= 1'b0;
            fv_q    <= {IBUF_WIN{1'b0}};
        end else begin
            arr_q   <= arr_d;
            count_q <= count_d;
            undf_q  <= undf_d;
            fv_q    <= fv_d;
        end
    end

    assign bus.ibuff_0     = arr_q[0];
    assign bus.ibuff_1     = arr_q[1];
    assign bus.ibuff_2     = arr_q[2];
    assign bus.ibuff_3     = arr_q[3];
    assign bus.ibuff_4     = arr_q[4];
    assign bus.ibuff_5     = arr_q[5];
    assign bus.ibuff_6     = arr_q[6];
    assign bus.fetch_valid = fv_q;
    assign bus.ibuf_cnt    = count_q;
    assign bus.ibuf_undf   = undf_q;
    assign bus.fill_rdy    = fill_rdy_s;

endmodule
